// File: rtl/apb_slave_mem_pkg.sv
// Shared types and address decode for the parametrised APB4 completer memory.
// The decode is argument-driven so any width/depth combination can reuse it.
package apb_slave_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      READY
   } state_e;

   localparam int unsigned WAIT_CNT_W = 4;

   typedef struct packed {
      logic [63:0] word_idx;
      logic        err;
   } decode_t;

   // A transfer errors when it is not word aligned or lands past the last word.
   function automatic decode_t decode_addr(input logic [63:0] addr,
                                           input int unsigned lane_bits,
                                           input int unsigned depth);
      decode_t     r;
      logic [63:0] low_mask;
      low_mask   = (64'd1 << lane_bits) - 64'd1;
      r.word_idx = addr >> lane_bits;
      r.err      = ((addr & low_mask) != 64'd0) || (r.word_idx >= 64'(depth));
      return r;
   endfunction

endpackage

// File: rtl/apb_mem_bank.sv
// Word storage with per-byte-lane write enables and a per-word valid vector.
// Read is combinational; the parent registers it into prdata.
module apb_mem_bank #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned IDX_W      = 8
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    we_i,
   input  logic [IDX_W-1:0]        idx_i,
   input  logic [DATA_WIDTH/8-1:0] strb_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    valid_o
);

   localparam int unsigned NB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]      valid_q;

   // NOTE: the data array has no reset; the valid vector alone decides whether
   // a word reads back as stored data or as zero, so clearing it is sufficient.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int b = 0; b < NB; b++) begin
            if (strb_i[b]) mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[idx_i] <= 1'b1;
      end
   end

   assign rdata_o = mem_q[idx_i];
   assign valid_o = valid_q[idx_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer memory: programmable wait states, byte-strobe writes and
// pslverr on misaligned or out-of-range accesses. All outputs are registered.
module apb_slave_mem
   import apb_slave_mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [2:0]              pprot,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic                    pready,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pslverr
);

   localparam int unsigned NB        = DATA_WIDTH / 8;
   localparam int unsigned LANE_BITS = $clog2(NB);
   localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

   state_e                  state_q;
   logic [WAIT_CNT_W-1:0]   cnt_q;
   logic                    pready_q;
   logic                    pslverr_q;
   logic [DATA_WIDTH-1:0]   prdata_q;

   decode_t                 dec;
   logic [IDX_W-1:0]        idx;
   logic [DATA_WIDTH-1:0]   prdata_d;
   logic                    pslverr_d;
   logic [DATA_WIDTH-1:0]   bank_rdata;
   logic                    bank_valid;
   logic                    mem_we;

   // Values captured on the edge that enters READY.
   always_comb begin
      dec       = decode_addr(64'(paddr), LANE_BITS, DEPTH);
      idx       = dec.word_idx[IDX_W-1:0];
      pslverr_d = dec.err;
      prdata_d  = (!dec.err && !pwrite && bank_valid) ? bank_rdata : '0;
   end

   // READY holds pready high, so psel & penable here is the completion edge.
   assign mem_we = (state_q == READY) && psel && penable && pwrite && !pslverr_q;

   apb_mem_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
   ) u_bank (
      .clk     (clk),
      .rstn    (rstn),
      .we_i    (mem_we),
      .idx_i   (idx),
      .strb_i  (pstrb),
      .wdata_i (pwdata),
      .rdata_o (bank_rdata),
      .valid_o (bank_valid)
   );

   // NOTE: outputs are updated in the same clocked block as the state, so they
   // are never a combinational function of the bus inputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (psel && !penable) begin
                  if (WAIT_STATES == 0) begin
                     state_q   <= READY;
                     pready_q  <= 1'b1;
                     prdata_q  <= prdata_d;
                     pslverr_q <= pslverr_d;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= WAIT_LOAD;
                  end
               end
            end
            WAIT: begin
               if (!psel) begin
                  state_q <= IDLE;
               end else if (cnt_q == '0) begin
                  state_q   <= READY;
                  pready_q  <= 1'b1;
                  prdata_q  <= prdata_d;
                  pslverr_q <= pslverr_d;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            READY: begin
               // Completion or abort both return to IDLE with outputs cleared.
               if (!psel || penable) begin
                  state_q   <= IDLE;
                  pready_q  <= 1'b0;
                  pslverr_q <= 1'b0;
                  prdata_q  <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pready  = pready_q;
   assign prdata  = prdata_q;
   assign pslverr = pslverr_q;

   logic unused_ok;
   assign unused_ok = ^{pprot, dec.word_idx};

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three instances (default, 3 wait states,
// 16-bit/16-deep) share one APB bus and are selected by individual psel bits.
module tb_apb_slave_mem;

   logic        clk = 1'b0;
   logic        rstn;
   logic [15:0] paddr;
   logic [2:0]  pprot;
   logic [2:0]  psel_v;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;

   logic [2:0]  pready_v;
   logic [2:0]  pslverr_v;
   logic [31:0] prdata0;
   logic [31:0] prdata1;
   logic [15:0] prdata2;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   apb_slave_mem #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) u_dut_ws0 (
      .clk(clk), .rstn(rstn), .paddr(paddr), .pprot(pprot), .psel(psel_v[0]),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .pready(pready_v[0]), .prdata(prdata0), .pslverr(pslverr_v[0]));

   apb_slave_mem #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(3)) u_dut_ws3 (
      .clk(clk), .rstn(rstn), .paddr(paddr), .pprot(pprot), .psel(psel_v[1]),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .pready(pready_v[1]), .prdata(prdata1), .pslverr(pslverr_v[1]));

   apb_slave_mem #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(16), .WAIT_STATES(0)) u_dut_w16 (
      .clk(clk), .rstn(rstn), .paddr(paddr), .pprot(pprot), .psel(psel_v[2]),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata[15:0]), .pstrb(pstrb[1:0]),
      .pready(pready_v[2]), .prdata(prdata2), .pslverr(pslverr_v[2]));

   function automatic logic [31:0] get_rdata(input int d);
      case (d)
         0:       return prdata0;
         1:       return prdata1;
         default: return {16'h0000, prdata2};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called #1 after a rising edge; returns #1 after the completion edge, so
   // an immediately following call issues its setup with no dead cycle.
   task automatic apb_xfer(input int d, input logic wr, input logic [15:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           output logic [31:0] rdata, output logic err,
                           output int waits, output logic quiet);
      psel_v    = '0;
      psel_v[d] = 1'b1;
      penable   = 1'b0;
      pwrite    = wr;
      paddr     = addr;
      pwdata    = data;
      pstrb     = strb;
      pprot     = 3'b010;
      @(posedge clk);
      #1 penable = 1'b1;
      waits = 0;
      quiet = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (pready_v[d]) break;
         waits++;
         if (get_rdata(d) != 32'h0 || pslverr_v[d]) quiet = 1'b0;
      end
      rdata = get_rdata(d);
      err   = pslverr_v[d];
      if (!pready_v[d]) waits = -1;
      @(posedge clk);
      #1;
      psel_v  = '0;
      penable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      logic        q;
      int          w;

      rstn    = 1'b0;
      psel_v  = '0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      pstrb   = '0;
      pprot   = '0;
      @(posedge clk);
      #1;
      check("rst_pready", {29'd0, pready_v}, 32'h0);
      check("rst_pslverr", {29'd0, pslverr_v}, 32'h0);
      check("rst_prdata0", prdata0, 32'h0);
      @(posedge clk);
      #1 rstn = 1'b1;
      idle(1);

      // ---------------- default instance ----------------
      apb_xfer(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, rd, er, w, q);
      check("w10_err", {31'd0, er}, 32'h0);
      check("w10_waits", w, 32'd0);
      idle(1);
      apb_xfer(0, 1'b0, 16'h0010, 32'h0, 4'h0, rd, er, w, q);
      check("r10_data", rd, 32'hDEADBEEF);
      check("r10_err", {31'd0, er}, 32'h0);
      check("r10_waits", w, 32'd0);
      idle(1);

      apb_xfer(0, 1'b1, 16'h0020, 32'h11223344, 4'hF, rd, er, w, q);
      idle(1);
      apb_xfer(0, 1'b1, 16'h0020, 32'hAABBCCDD, 4'h5, rd, er, w, q);
      idle(1);
      apb_xfer(0, 1'b0, 16'h0020, 32'h0, 4'h0, rd, er, w, q);
      check("r20_strobe_merge", rd, 32'h11BB33DD);
      idle(1);

      apb_xfer(0, 1'b0, 16'h0040, 32'h0, 4'hF, rd, er, w, q);
      check("r40_unwritten", rd, 32'h0);
      check("r40_err", {31'd0, er}, 32'h0);
      idle(1);

      apb_xfer(0, 1'b0, 16'h0400, 32'h0, 4'h0, rd, er, w, q);
      check("r400_err", {31'd0, er}, 32'h1);
      check("r400_data", rd, 32'h0);
      idle(1);

      apb_xfer(0, 1'b1, 16'h0000, 32'h12345678, 4'hF, rd, er, w, q);
      idle(1);
      apb_xfer(0, 1'b1, 16'h0002, 32'h00000055, 4'hF, rd, er, w, q);
      check("w2_misaligned_err", {31'd0, er}, 32'h1);
      idle(1);
      apb_xfer(0, 1'b0, 16'h0000, 32'h0, 4'h0, rd, er, w, q);
      check("r0_unchanged", rd, 32'h12345678);
      check("r0_err", {31'd0, er}, 32'h0);
      idle(1);

      // Asynchronous reset while the default instance is in READY.
      psel_v  = 3'b001;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = 16'h0010;
      @(posedge clk);
      #1 penable = 1'b1;
      @(negedge clk);
      check("ready_pre_rst_pready", {31'd0, pready_v[0]}, 32'h1);
      check("ready_pre_rst_data", prdata0, 32'hDEADBEEF);
      #1 rstn = 1'b0;
      #1;
      check("ready_rst_pready", {31'd0, pready_v[0]}, 32'h0);
      check("ready_rst_data", prdata0, 32'h0);
      psel_v  = '0;
      penable = 1'b0;
      @(posedge clk);
      #1 rstn = 1'b1;
      idle(1);
      apb_xfer(0, 1'b0, 16'h0010, 32'h0, 4'h0, rd, er, w, q);
      check("r10_after_rst", rd, 32'h0);
      idle(1);

      // ---------------- three wait states ----------------
      apb_xfer(1, 1'b1, 16'h0008, 32'hCAFEF00D, 4'hF, rd, er, w, q);
      check("ws3_w8_waits", w, 32'd3);
      check("ws3_w8_err", {31'd0, er}, 32'h0);
      idle(1);
      apb_xfer(1, 1'b0, 16'h0008, 32'h0, 4'h0, rd, er, w, q);
      check("ws3_r8_waits", w, 32'd3);
      check("ws3_r8_quiet", {31'd0, q}, 32'h1);
      check("ws3_r8_data", rd, 32'hCAFEF00D);
      idle(1);
      apb_xfer(1, 1'b0, 16'h0400, 32'h0, 4'h0, rd, er, w, q);
      check("ws3_r400_waits", w, 32'd3);
      check("ws3_r400_quiet", {31'd0, q}, 32'h1);
      check("ws3_r400_err", {31'd0, er}, 32'h1);
      idle(1);

      // Reset in the middle of the wait phase of a write to 0x0008.
      psel_v  = 3'b010;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 16'h0008;
      pwdata  = 32'h0BADF00D;
      pstrb   = 4'hF;
      @(posedge clk);
      #1 penable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1 rstn = 1'b0;
      #1;
      check("ws3_rst_pready", {31'd0, pready_v[1]}, 32'h0);
      check("ws3_rst_pslverr", {31'd0, pslverr_v[1]}, 32'h0);
      check("ws3_rst_prdata", prdata1, 32'h0);
      psel_v  = '0;
      penable = 1'b0;
      @(posedge clk);
      #1 rstn = 1'b1;
      idle(1);
      apb_xfer(1, 1'b0, 16'h0008, 32'h0, 4'h0, rd, er, w, q);
      check("ws3_r8_after_rst", rd, 32'h0);
      check("ws3_r8_after_rst_err", {31'd0, er}, 32'h0);
      idle(1);

      // ---------------- 16-bit, 16 deep, back-to-back ----------------
      apb_xfer(2, 1'b1, 16'h0000, 32'h0000BEEF, 4'h3, rd, er, w, q);
      apb_xfer(2, 1'b1, 16'h0002, 32'h00001234, 4'h3, rd, er, w, q);
      check("w16_b2b_waits", w, 32'd0);
      apb_xfer(2, 1'b0, 16'h0000, 32'h0, 4'h0, rd, er, w, q);
      check("w16_r0", rd, 32'h0000BEEF);
      apb_xfer(2, 1'b0, 16'h0002, 32'h0, 4'h0, rd, er, w, q);
      check("w16_r2", rd, 32'h00001234);
      check("w16_r2_err", {31'd0, er}, 32'h0);
      idle(1);
      apb_xfer(2, 1'b0, 16'h0020, 32'h0, 4'h0, rd, er, w, q);
      check("w16_r20_err", {31'd0, er}, 32'h1);
      check("w16_r20_data", rd, 32'h0);
      idle(1);
      apb_xfer(2, 1'b0, 16'h0001, 32'h0, 4'h0, rd, er, w, q);
      check("w16_r1_misaligned", {31'd0, er}, 32'h1);
      idle(2);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

Parametrised APB4 completer memory model, successor to the fixed 16-bit/32-bit testbench slave. Adds configurable address/data width and depth, programmable wait states, byte-strobe writes, and `pslverr` on out-of-range or misaligned accesses. Sits on the testbench side of the APB master under test as the default completer.

## Interface
- `ADDR_WIDTH`, 16: `paddr` width.
- `DATA_WIDTH`, 32: data width; legal values 8, 16, 32.
- `DEPTH`, 256: number of `DATA_WIDTH` words of storage.
- `WAIT_STATES`, 0: `pready`-low cycles inserted in each access phase; range 0..15.
- `clk` in 1: clock; all logic on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `paddr` in `ADDR_WIDTH`: byte address.
- `pprot` in 3: protection attributes; accepted, no effect on behaviour.
- `psel` in 1: select.
- `penable` in 1: access phase.
- `pwrite` in 1: 1 = write, 0 = read.
- `pwdata` in `DATA_WIDTH`: write data.
- `pstrb` in `DATA_WIDTH/8`: write byte lanes.
- `pready` out 1: transfer complete.
- `prdata` out `DATA_WIDTH`: read data.
- `pslverr` out 1: transfer error.

## Operation
- FSM states:
  - IDLE → WAIT on setup (`psel & !penable`) when `WAIT_STATES > 0`; counter loads `WAIT_STATES-1`.
  - IDLE → READY on setup when `WAIT_STATES == 0`.
  - WAIT: counter decrements each cycle; → READY when the counter is 0.
  - READY → IDLE on the completion edge (`psel & penable & pready`).
- Error check, evaluated when entering READY:
  - Word index is `paddr >> log2(DATA_WIDTH/8)`.
  - Error if the word index is `>= DEPTH`, or if the low `log2(DATA_WIDTH/8)` address bits are nonzero.
- Write, non-error: at the completion edge, updates only the byte lanes with their `pstrb` bit set, and sets the word's valid bit.
- Write, error: storage unchanged.
- Read: `prdata` is loaded when entering READY.
  - Stored word if the valid bit is set.
  - 0 if the word was never written, or on error.
- `pstrb` is ignored on reads.
- `pslverr` is high only while `pready` is high, and only for an errored transfer.
- Abort: `psel` low in WAIT or READY → IDLE next cycle, no write, outputs return to 0.
- Reset, asynchronous, including mid-transfer:
  - FSM → IDLE.
  - `pready`, `prdata`, `pslverr` = 0.
  - All valid bits cleared.
  - Storage data is not reset.

## Timing
- Access phase lasts `WAIT_STATES+1` cycles.
  - `pready` is low for the first `WAIT_STATES` access cycles and high in the last.
  - With `WAIT_STATES = 0`, `pready` is high in the first access cycle.
- `pready`, `prdata`, `pslverr` are registered: no combinational path from inputs to outputs.
- Outputs are 0 in every cycle except READY.
- Back-to-back: setup of the next transfer in the cycle after completion is accepted with no dead cycle.
- Read after write to the same address in consecutive transfers returns the new data.

## Structure
- `apb_slave_mem_pkg`:
  - State enum: IDLE, WAIT, READY.
  - Function computing the word index and error flag from the address, parameterised via arguments.
- Sub-module `apb_mem_bank`:
  - `DEPTH` × `DATA_WIDTH` storage with per-lane write enables, plus a valid-bit vector.
  - Valid vector asynchronously cleared by `rstn`.
  - Read is combinational; it is registered in the parent.

## Test plan
- Default parameters; write 0xDEADBEEF to 0x0010 with `pstrb`=0xF, then read 0x0010 → `prdata`=0xDEADBEEF, `pslverr`=0, `pready` high in the first access cycle.
- Write 0x11223344 to 0x0020, then write 0xAABBCCDD with `pstrb`=0x5, then read → 0x11BB33DD.
- Read 0x0040, never written → 0. Read 0x0400 (index 256 ≥ `DEPTH`) → `pslverr`=1, `prdata`=0. Write 0x55 to 0x0002 (misaligned) → `pslverr`=1, and a later read of 0x0000 is unchanged.
- `WAIT_STATES`=3:
  - `pready` low for exactly 3 access cycles, high in the 4th.
  - `pslverr`/`prdata` stay 0 until then.
- Assert `rstn`=0 mid-WAIT on a write to 0x0008:
  - Outputs are 0 immediately.
  - After release, read 0x0008 → 0.
- `DATA_WIDTH`=16, `DEPTH`=16:
  - Back-to-back writes to 0x0000 and 0x0002 with no idle cycle, then reads → both values returned.
  - Read 0x0020 → `pslverr`=1.
